// File: rtl/dz_pkg.sv
// Shared types and glyph data for the bi-colour dot-matrix scan controller.
// Glyphs are stored row0..row7 from the most significant byte down; bit7 is the leftmost column.
package dz_pkg;

    typedef enum logic [1:0] {
        COL_OFF = 2'd0,
        COL_RED = 2'd1,
        COL_GRN = 2'd2,
        COL_YEL = 2'd3
    } col_t;

    localparam logic [3:0] GLYPH_BLANK = 4'hF;
    localparam int         NUM_ROWS    = 8;

    function automatic logic [63:0] glyph_rows(input logic [3:0] code);
        case (code)
            4'd0:    return 64'h3C6666666666663C;
            4'd1:    return 64'h183818181818187E;
            4'd2:    return 64'h3C66060C1830607E;
            4'd3:    return 64'h3C66061C0606663C;
            4'd4:    return 64'h0C1C3C6C7E0C0C0C;
            4'd5:    return 64'h7E607C060606663C;
            4'd6:    return 64'h3C66607C6666663C;
            4'd7:    return 64'h7E060C1830303030;
            4'd8:    return 64'h3C66663C6666663C;
            4'd9:    return 64'h3C6666663E06663C;
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic [7:0] glyph_row(input logic [3:0] code, input logic [2:0] row);
        logic [63:0] w_rows;
        w_rows = glyph_rows(code);
        return w_rows[8*(7 - int'(row)) +: 8];
    endfunction

endpackage

// File: rtl/dz_scan_ctrl_if.sv
// Control/display bundle between the digit logic (master) and the scan controller (slave).
interface dz_scan_ctrl_if #(
    parameter int PWM_BITS = 2
);
    logic [3:0]          num;
    logic [1:0]          color;
    logic [PWM_BITS-1:0] bright;
    logic                load;
    logic [7:0]          row;
    logic [7:0]          colr;
    logic [7:0]          colg;
    logic                frame_done;

    modport master (
        output num, color, bright, load,
        input  row, colr, colg, frame_done
    );

    modport slave (
        input  num, color, bright, load,
        output row, colr, colg, frame_done
    );
endinterface

// File: rtl/dz_glyph_rom.sv
// Combinational glyph lookup: (code, row) -> column bits; codes 10-15 read as blank.
module dz_glyph_rom
    import dz_pkg::*;
(
    input  logic [3:0] i_code,
    input  logic [2:0] i_row,
    output logic [7:0] o_bits
);

    always_comb begin
        o_bits = '0;
        if (i_code < 4'd10) begin
            o_bits = glyph_row(i_code, i_row);
        end
    end

endmodule

// File: rtl/dz_scan_ctrl.sv
// 8x8 red/green dot-matrix scanner: per-row PWM lit window, optional blanking gap,
// and glyph/colour/brightness changes applied only at frame boundaries.
module dz_scan_ctrl
    import dz_pkg::*;
#(
    parameter int PWM_BITS   = 2,
    parameter int BLANK_CYC  = 1,
    parameter int ROW_ACT_LO = 1
) (
    input  logic           clk,
    input  logic           rst,
    dz_scan_ctrl_if.slave  bus
);

    localparam int         LIT_CYC  = 2 ** PWM_BITS;
    localparam int         T_CYC    = LIT_CYC + BLANK_CYC;
    localparam int         PH_W     = (T_CYC > 1) ? $clog2(T_CYC) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(T_CYC - 1);
    localparam logic [7:0] ROW_IDLE = (ROW_ACT_LO != 0) ? 8'hFF : 8'h00;

    logic [2:0]          r_row_idx;
    logic [PH_W-1:0]     r_phase;

    logic [3:0]          r_pend_num;
    col_t                r_pend_col;
    logic [PWM_BITS-1:0] r_pend_bright;
    logic [3:0]          r_act_num;
    col_t                r_act_col;
    logic [PWM_BITS-1:0] r_act_bright;

    logic [7:0]          r_row;
    logic [7:0]          r_colr;
    logic [7:0]          r_colg;
    logic                r_frame_done;

    logic [7:0]          w_bits;
    logic [7:0]          w_sel;
    logic                w_lit;
    logic                w_on;
    logic                w_frame_end;

    dz_glyph_rom u_rom (
        .i_code (r_act_num),
        .i_row  (r_row_idx),
        .o_bits (w_bits)
    );

    always_comb begin
        w_sel       = 8'b0000_0001 << r_row_idx;
        w_lit       = ({1'b0, r_phase} < (PH_W + 1)'(LIT_CYC));
        w_on        = w_lit && (r_phase <= PH_W'(r_act_bright));
        w_frame_end = (r_row_idx == 3'd7) && (r_phase == PH_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_idx     <= '0;
            r_phase       <= '0;
            r_pend_num    <= GLYPH_BLANK;
            r_pend_col    <= COL_OFF;
            r_pend_bright <= '0;
            r_act_num     <= GLYPH_BLANK;
            r_act_col     <= COL_OFF;
            r_act_bright  <= '0;
            r_row         <= ROW_IDLE;
            r_colr        <= '0;
            r_colg        <= '0;
            r_frame_done  <= 1'b0;
        end else begin
            if (bus.load) begin
                r_pend_num    <= bus.num;
                r_pend_col    <= col_t'(bus.color);
                r_pend_bright <= bus.bright;
            end

            // A load coinciding with the boundary bypasses pending so it lands in the next frame.
            if (w_frame_end) begin
                r_act_num    <= bus.load ? bus.num            : r_pend_num;
                r_act_col    <= bus.load ? col_t'(bus.color)  : r_pend_col;
                r_act_bright <= bus.load ? bus.bright         : r_pend_bright;
            end

            if (r_phase == PH_LAST) begin
                r_phase   <= '0;
                r_row_idx <= r_row_idx + 3'd1;
            end else begin
                r_phase <= r_phase + PH_W'(1);
            end

            r_row        <= w_lit ? ((ROW_ACT_LO != 0) ? ~w_sel : w_sel) : ROW_IDLE;
            r_colr       <= (w_on && r_act_col[0]) ? w_bits : 8'h00;
            r_colg       <= (w_on && r_act_col[1]) ? w_bits : 8'h00;
            r_frame_done <= (r_row_idx == 3'd0) && (r_phase == '0);
        end
    end

    assign bus.row        = r_row;
    assign bus.colr       = r_colr;
    assign bus.colg       = r_colg;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_dz_scan_ctrl.sv
// Bench for dz_scan_ctrl at PWM_BITS=2, BLANK_CYC=1, ROW_ACT_LO=1 (5-cycle rows, 40-cycle frames).
module tb_dz_scan_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dz_scan_ctrl_if #(.PWM_BITS(2)) bus ();

    dz_scan_ctrl #(
        .PWM_BITS   (2),
        .BLANK_CYC  (1),
        .ROW_ACT_LO (1)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] font [10][8] = '{
        '{8'h3C, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h3C},
        '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E},
        '{8'h3C, 8'h66, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'h7E},
        '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h06, 8'h66, 8'h3C},
        '{8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h0C},
        '{8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h06, 8'h66, 8'h3C},
        '{8'h3C, 8'h66, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h3C},
        '{8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h30},
        '{8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h66, 8'h3C},
        '{8'h3C, 8'h66, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h66, 8'h3C}
    };

    // Reference: position within the 40-cycle frame, last loaded settings, settings shown this frame.
    int         m_t;
    logic [3:0] m_pn, m_an;
    logic [1:0] m_pc, m_ac;
    logic [1:0] m_pb, m_ab;

    task automatic model_reset();
        m_t  = 0;
        m_pn = 4'hF; m_pc = 2'd0; m_pb = 2'd0;
        m_an = 4'hF; m_ac = 2'd0; m_ab = 2'd0;
    endtask

    function automatic void expect_out(input int t, input logic [3:0] n, input logic [1:0] c,
                                       input logic [1:0] b, output logic [7:0] er,
                                       output logic [7:0] ecr, output logic [7:0] ecg,
                                       output logic efd);
        int         r;
        int         ph;
        logic [7:0] bits;
        r    = t / 5;
        ph   = t % 5;
        bits = (n < 10) ? font[n][r] : 8'h00;
        if (!(ph < 4 && ph <= int'(b))) bits = 8'h00;
        er   = (ph < 4) ? ~(8'h01 << r) : 8'hFF;
        ecr  = c[0] ? bits : 8'h00;
        ecg  = c[1] ? bits : 8'h00;
        efd  = (t == 0);
    endfunction

    // One clock: apply inputs, sample outputs 1 time unit after the edge, advance the reference.
    task automatic tick(input logic ld, input logic [3:0] n, input logic [1:0] c,
                        input logic [1:0] b, output logic [7:0] er, output logic [7:0] ecr,
                        output logic [7:0] ecg, output logic efd);
        bus.load   = ld;
        bus.num    = ld ? n : 4'($urandom);
        bus.color  = ld ? c : 2'($urandom);
        bus.bright = ld ? b : 2'($urandom);
        @(posedge clk);
        #1;
        expect_out(m_t, m_an, m_ac, m_ab, er, ecr, ecg, efd);
        if (m_t == 39) begin
            if (ld) begin m_an = n;    m_ac = c;    m_ab = b;    end
            else    begin m_an = m_pn; m_ac = m_pc; m_ab = m_pb; end
        end
        if (ld) begin m_pn = n; m_pc = c; m_pb = b; end
        m_t = (m_t + 1) % 40;
        bus.load = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] er, ecr, ecg;
        logic       efd;
        int         pulses = 0;
        rst = 1'b1;
        bus.load = 1'b0; bus.num = 4'd0; bus.color = 2'd0; bus.bright = 2'd0;
        #2;
        checks++;
        if ({bus.row, bus.colr, bus.colg, bus.frame_done} !== {8'hFF, 8'h00, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_state row=%h colr=%h colg=%h fd=%b want FF 00 00 0",
                     bus.row, bus.colr, bus.colg, bus.frame_done);
        end
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 80; i++) begin
            tick(1'b0, 4'd0, 2'd0, 2'd0, er, ecr, ecg, efd);
            if (bus.frame_done === 1'b1) pulses++;
            checks++;
            if ({bus.row, bus.colr, bus.colg, bus.frame_done} !== {er, ecr, ecg, efd}) begin
                errors++;
                $display("FAIL reset_scan i=%0d row=%h/%h colr=%h/%h colg=%h/%h fd=%b/%b", i,
                         bus.row, er, bus.colr, ecr, bus.colg, ecg, bus.frame_done, efd);
            end
        end
        checks++;
        if (pulses !== 2) begin
            errors++;
            $display("FAIL reset_fd_count got=%0d want=2", pulses);
        end
    endtask

    task automatic test_green_one();
        logic [7:0] er, ecr, ecg;
        logic       efd;
        bit         found = 0;
        tick(1'b1, 4'd1, 2'd2, 2'd3, er, ecr, ecg, efd);
        for (int i = 0; i < 50 && !found; i++) begin
            tick(1'b0, 4'd0, 2'd0, 2'd0, er, ecr, ecg, efd);
            found = (bus.frame_done === 1'b1);
            checks++;
            if ({bus.row, bus.colr, bus.colg, bus.frame_done} !== {er, ecr, ecg, efd}) begin
                errors++;
                $display("FAIL green_wait i=%0d row=%h/%h colr=%h/%h colg=%h/%h fd=%b/%b", i,
                         bus.row, er, bus.colr, ecr, bus.colg, ecg, bus.frame_done, efd);
            end
        end
        checks++;
        if (!found || bus.colg !== 8'h18 || bus.row !== 8'hFE) begin
            errors++;
            $display("FAIL green_row0 found=%0d row=%h colg=%h want FE 18", found, bus.row, bus.colg);
        end
        for (int i = 0; i < 39; i++) begin
            tick(1'b0, 4'd0, 2'd0, 2'd0, er, ecr, ecg, efd);
            checks++;
            if ({bus.row, bus.colr, bus.colg, bus.frame_done} !== {er, ecr, ecg, efd}) begin
                errors++;
                $display("FAIL green_frame i=%0d row=%h/%h colr=%h/%h colg=%h/%h fd=%b/%b", i,
                         bus.row, er, bus.colr, ecr, bus.colg, ecg, bus.frame_done, efd);
            end
        end
    endtask

    task automatic test_yellow_dim();
        logic [7:0] er, ecr, ecg;
        logic       efd;
        tick(1'b1, 4'd0, 2'd3, 2'd0, er, ecr, ecg, efd);
        for (int i = 0; i < 80; i++) begin
            tick(1'b0, 4'd0, 2'd0, 2'd0, er, ecr, ecg, efd);
            checks++;
            if ({bus.row, bus.colr, bus.colg, bus.frame_done} !== {er, ecr, ecg, efd}) begin
                errors++;
                $display("FAIL yellow_dim i=%0d row=%h/%h colr=%h/%h colg=%h/%h fd=%b/%b", i,
                         bus.row, er, bus.colr, ecr, bus.colg, ecg, bus.frame_done, efd);
            end
        end
    endtask

    task automatic test_midframe_load();
        logic [7:0] er, ecr, ecg;
        logic       efd;
        tick(1'b1, 4'd0, 2'd2, 2'd3, er, ecr, ecg, efd);
        for (int i = 0; i < 40 || m_t != 15; i++) begin
            tick(1'b0, 4'd0, 2'd0, 2'd0, er, ecr, ecg, efd);
            checks++;
            if ({bus.row, bus.colr, bus.colg, bus.frame_done} !== {er, ecr, ecg, efd}) begin
                errors++;
                $display("FAIL mid_pre i=%0d row=%h/%h colr=%h/%h colg=%h/%h fd=%b/%b", i,
                         bus.row, er, bus.colr, ecr, bus.colg, ecg, bus.frame_done, efd);
            end
        end
        // Load during row 3, then another load on the very boundary cycle of the following frame.
        for (int i = 0; i < 65; i++) begin
            tick(i == 0 || i == 64, (i == 0) ? 4'd1 : 4'd7, 2'd2, 2'd3, er, ecr, ecg, efd);
            checks++;
            if ({bus.row, bus.colr, bus.colg, bus.frame_done} !== {er, ecr, ecg, efd}) begin
                errors++;
                $display("FAIL mid_load i=%0d row=%h/%h colr=%h/%h colg=%h/%h fd=%b/%b", i,
                         bus.row, er, bus.colr, ecr, bus.colg, ecg, bus.frame_done, efd);
            end
        end
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 4'd0, 2'd0, 2'd0, er, ecr, ecg, efd);
            checks++;
            if ({bus.row, bus.colr, bus.colg, bus.frame_done} !== {er, ecr, ecg, efd}) begin
                errors++;
                $display("FAIL mid_boundary i=%0d row=%h/%h colr=%h/%h colg=%h/%h fd=%b/%b", i,
                         bus.row, er, bus.colr, ecr, bus.colg, ecg, bus.frame_done, efd);
            end
        end
    endtask

    task automatic test_blank_glyph();
        logic [7:0] er, ecr, ecg;
        logic       efd;
        int         pulses = 0;
        tick(1'b1, 4'd12, 2'd1, 2'd3, er, ecr, ecg, efd);
        for (int i = 0; i < 80; i++) begin
            tick(1'b0, 4'd0, 2'd0, 2'd0, er, ecr, ecg, efd);
            if (bus.frame_done === 1'b1) pulses++;
            checks++;
            if ({bus.row, bus.colr, bus.colg, bus.frame_done} !== {er, ecr, ecg, efd}) begin
                errors++;
                $display("FAIL blank_glyph i=%0d row=%h/%h colr=%h/%h colg=%h/%h fd=%b/%b", i,
                         bus.row, er, bus.colr, ecr, bus.colg, ecg, bus.frame_done, efd);
            end
        end
        checks++;
        if (pulses !== 2) begin
            errors++;
            $display("FAIL blank_fd_count got=%0d want=2", pulses);
        end
    endtask

    task automatic test_random();
        logic [7:0] er, ecr, ecg;
        logic       efd;
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 7) == 0, 4'($urandom), 2'($urandom), 2'($urandom),
                 er, ecr, ecg, efd);
            checks++;
            if ({bus.row, bus.colr, bus.colg, bus.frame_done} !== {er, ecr, ecg, efd}) begin
                errors++;
                $display("FAIL random i=%0d row=%h/%h colr=%h/%h colg=%h/%h fd=%b/%b", i,
                         bus.row, er, bus.colr, ecr, bus.colg, ecg, bus.frame_done, efd);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] er, ecr, ecg;
        logic       efd;
        tick(1'b1, 4'd8, 2'd3, 2'd3, er, ecr, ecg, efd);
        for (int i = 0; i < 40 || m_t != 27; i++) begin
            tick(1'b0, 4'd0, 2'd0, 2'd0, er, ecr, ecg, efd);
        end
        checks++;
        if (bus.row !== 8'hDF || bus.colr === 8'h00) begin
            errors++;
            $display("FAIL rst_mid_pre row=%h colr=%h want DF and lit", bus.row, bus.colr);
        end
        rst = 1'b1;
        #2;
        checks++;
        if ({bus.row, bus.colr, bus.colg, bus.frame_done} !== {8'hFF, 8'h00, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_async row=%h colr=%h colg=%h fd=%b want FF 00 00 0",
                     bus.row, bus.colr, bus.colg, bus.frame_done);
        end
        @(posedge clk); #3;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 4'd0, 2'd0, 2'd0, er, ecr, ecg, efd);
            checks++;
            if ({bus.row, bus.colr, bus.colg, bus.frame_done} !== {er, ecr, ecg, efd}) begin
                errors++;
                $display("FAIL rst_mid_after i=%0d row=%h/%h colr=%h/%h colg=%h/%h fd=%b/%b", i,
                         bus.row, er, bus.colr, ecr, bus.colg, ecg, bus.frame_done, efd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_green_one();
        test_yellow_dim();
        test_midframe_load();
        test_blank_glyph();
        test_random();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
